// File: rtl/mc_cpu_core.sv
// Multi-cycle MIPS-subset core with a shared ready-handshake memory port and per-channel debug register reads.
// Optional build macro MC_CPU_PERF_CNT_EN adds the cycle_cnt / instr_cnt performance counter ports.
module mc_cpu_core #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          DBG_CH       = 4,
    parameter bit          ILLEGAL_HALT = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    output logic [31:0]         mem_addr,
    output logic                mem_re,
    output logic                mem_we,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,
    input  logic                mem_ready,
    input  logic [5*DBG_CH-1:0] dbg_sel,
    output logic [32*DBG_CH-1:0] dbg_data,
    output logic [31:0]         pc_o,
    output logic                retire,
    output logic                halted,
`ifdef MC_CPU_PERF_CNT_EN
    output logic [31:0]         cycle_cnt,
    output logic [31:0]         instr_cnt,
`endif
    output logic [2:0]          core_state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t      state;
    logic [31:0] pc, ir, a, b, alu_out, mdr;
    logic [31:0] regs [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] imm26;
    logic [31:0] simm;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign funct = ir[5:0];
    assign imm   = ir[15:0];
    assign imm26 = ir[25:0];
    assign simm  = {{16{imm[15]}}, imm};

    logic is_rtype, r_ok, is_jr, is_j, is_jal, is_beq, is_lw, is_sw, is_addiu, is_lui, legal;

    always_comb begin
        is_rtype = (op == 6'h00);
        r_ok     = 1'b0;
        case (funct)
            6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h08: r_ok = 1'b1;
            default: r_ok = 1'b0;
        endcase
        is_jr    = is_rtype && (funct == 6'h08);
        is_j     = (op == 6'h02);
        is_jal   = (op == 6'h03);
        is_beq   = (op == 6'h04);
        is_addiu = (op == 6'h09);
        is_lui   = (op == 6'h0F);
        is_lw    = (op == 6'h23);
        is_sw    = (op == 6'h2B);
        legal    = (is_rtype && r_ok) || is_j || is_jal || is_beq ||
                   is_addiu || is_lui || is_lw || is_sw;
    end

    logic [31:0] alu_y;

    always_comb begin
        alu_y = 32'd0;
        if (is_rtype) begin
            case (funct)
                6'h21:   alu_y = a + b;
                6'h23:   alu_y = a - b;
                6'h24:   alu_y = a & b;
                6'h25:   alu_y = a | b;
                6'h2A:   alu_y = {31'd0, $signed(a) < $signed(b)};
                6'h00:   alu_y = b << shamt;
                default: alu_y = 32'd0;
            endcase
        end else if (is_addiu || is_lw || is_sw) begin
            alu_y = a + simm;
        end else if (is_lui) begin
            alu_y = {imm, 16'd0};
        end
    end

    // Single register-file write port shared by jal (link in DECODE) and WB.
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (state == DECODE && legal && is_jal) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc;
        end else if (state == WB) begin
            rf_we    = 1'b1;
            rf_waddr = is_rtype ? rd : rt;
            rf_wdata = is_lw ? mdr : alu_out;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            ir      <= 32'd0;
            a       <= 32'd0;
            b       <= 32'd0;
            alu_out <= 32'd0;
            mdr     <= 32'd0;
            halted  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        pc    <= pc + 32'd4;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    a       <= regs[rs];
                    b       <= regs[rt];
                    alu_out <= pc + (simm << 2);
                    if (!legal) begin
                        if (ILLEGAL_HALT) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            state  <= FETCH;
                        end
                    end else if (is_j || is_jal) begin
                        pc    <= {pc[31:28], imm26, 2'b00};
                        state <= FETCH;
                    end else if (is_jr) begin
                        pc    <= regs[rs];
                        state <= FETCH;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_beq) begin
                        if (a == b) pc <= alu_out;
                        state <= FETCH;
                    end else begin
                        alu_out <= alu_y;
                        state   <= (is_lw || is_sw) ? MEM : WB;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        if (is_lw) begin
                            mdr   <= mem_rdata;
                            state <= WB;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                WB:      state <= FETCH;
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // Requests are decoded from state so a zero-wait memory completes in the same cycle;
    // gating with reset drops an in-flight request the moment reset rises.
    assign mem_re    = !reset && (state == FETCH || (state == MEM && is_lw));
    assign mem_we    = !reset && (state == MEM && is_sw);
    assign mem_addr  = (state == MEM) ? alu_out : pc;
    assign mem_wdata = b;
    assign pc_o      = pc;
    assign core_state = state;

    always_comb begin
        retire = 1'b0;
        case (state)
            DECODE:  retire = legal ? (is_j || is_jal || is_jr) : !ILLEGAL_HALT;
            EXEC:    retire = is_beq;
            MEM:     retire = is_sw && mem_ready;
            WB:      retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    for (genvar g = 0; g < DBG_CH; g++) begin : g_dbg
        assign dbg_data[32*g +: 32] = regs[dbg_sel[5*g +: 5]];
    end

`ifdef MC_CPU_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= 32'd0;
            instr_cnt <= 32'd0;
        end else begin
            if (state != HALT) cycle_cnt <= cycle_cnt + 32'd1;
            if (retire)        instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed bench for mc_cpu_core: small programs in a word memory with programmable wait states.
// Counter checks are compiled in when MC_CPU_PERF_CNT_EN is defined.
module tb_mc_cpu_core;

    localparam int DBG_CH = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [31:0]          mem_addr, mem_wdata, mem_rdata;
    logic                 mem_re, mem_we, mem_ready;
    logic [5*DBG_CH-1:0]  dbg_sel = '0;
    logic [32*DBG_CH-1:0] dbg_data;
    logic [31:0]          pc_o;
    logic                 retire, halted;
    logic [2:0]           core_state;
`ifdef MC_CPU_PERF_CNT_EN
    logic [31:0]          cycle_cnt, instr_cnt;
`endif

    mc_cpu_core #(.RESET_PC(32'h0), .DBG_CH(DBG_CH), .ILLEGAL_HALT(1'b1)) dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data),
        .pc_o(pc_o), .retire(retire), .halted(halted),
`ifdef MC_CPU_PERF_CNT_EN
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
`endif
        .core_state(core_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Memory model: program words plus a one-entry store overlay so lw sees sw data
    logic [31:0] mem [256];
    int          re_wait = 0, we_wait = 0, wait_ctr = 0;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0, st_data = '0;

    assign mem_ready = mem_we ? (wait_ctr >= we_wait) : (wait_ctr >= re_wait);
    assign mem_rdata = (st_valid && mem_addr == st_addr) ? st_data : mem[mem_addr[9:2]];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_ctr <= 0;
            st_valid <= 1'b0;
        end else if (mem_re || mem_we) begin
            if (mem_ready) begin
                wait_ctr <= 0;
                if (mem_we) begin
                    st_valid <= 1'b1;
                    st_addr  <= mem_addr;
                    st_data  <= mem_wdata;
                end
            end else begin
                wait_ctr <= wait_ctr + 1;
            end
        end else begin
            wait_ctr <= 0;
        end
    end

    // Scoreboard
    int          n_chk = 0, n_err = 0;
    int          cyc = 0, we_cycles = 0, we_bad = 0, re_cycles = 0, both = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ret_q[$];
    logic [31:0] pc_hist[$];
    logic [31:0] exp_st_addr = '0, exp_st_data = '0;
    logic [31:0] rv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    // Driver tasks
    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete(); ret_q.delete(); pc_hist.delete();
        cyc = 0; we_cycles = 0; we_bad = 0; re_cycles = 0; both = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // Samples one cycle then advances to 1 time unit past the next falling edge.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            cyc++;
            pc_hist.push_back(pc_o);
            if (retire) ret_q.push_back(cyc);
            if (mem_re) re_cycles++;
            if (mem_we) begin
                we_cycles++;
                if (mem_addr !== exp_st_addr || mem_wdata !== exp_st_data) we_bad++;
            end
            if (mem_re && mem_we) both++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic get_reg(input logic [4:0] idx, output logic [31:0] v);
        dbg_sel[4:0] = idx;
        #1;
        v = dbg_data[31:0];
    endtask

    task automatic check_retires(input string tag);
        check({tag, "_n"}, ret_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check(tag, (i < ret_q.size()) ? ret_q[i] : 32'hFFFF_FFFF, exp_q[i]);
    endtask

    initial begin
        clear_mem();

        // Reset state, sampled while reset is held
        @(negedge clk);
        #1;
        check("rst_mem_re", {31'd0, mem_re}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_retire", {31'd0, retire}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_state", {29'd0, core_state}, 32'd0);
        get_reg(5'd4, rv);
        check("rst_gpr4", rv, 32'd0);

        // addiu pair, zero wait
        mem[0] = 32'h2404_0005;   // addiu $4,$0,5
        mem[1] = 32'h2482_FFF9;   // addiu $2,$4,-7
        do_reset();
        check("fetch_re", {31'd0, mem_re}, 32'd1);
        check("fetch_addr", mem_addr, 32'h0);
        run(8);
        exp_q.push_back(4); exp_q.push_back(8);
        check_retires("addiu_ret");
        check("addiu_pc", pc_o, 32'h8);
        get_reg(5'd4, rv); check("addiu_r4", rv, 32'd5);
        get_reg(5'd2, rv); check("addiu_r2", rv, 32'hFFFF_FFFE);

        // ALU ops, read back over all four debug channels
        clear_mem();
        mem[0] = enc_i(6'h0F, 5'd0, 5'd5, 16'h8000);   // lui   $5,0x8000
        mem[1] = enc_i(6'h09, 5'd0, 5'd6, 16'd3);      // addiu $6,$0,3
        mem[2] = enc_r(5'd5, 5'd6, 5'd7, 5'd0, 6'h2A); // slt   $7,$5,$6
        mem[3] = enc_r(5'd6, 5'd5, 5'd8, 5'd0, 6'h23); // subu  $8,$6,$5
        mem[4] = enc_r(5'd8, 5'd6, 5'd9, 5'd0, 6'h24); // and   $9,$8,$6
        mem[5] = enc_r(5'd5, 5'd6, 5'd10, 5'd0, 6'h25);// or    $10,$5,$6
        mem[6] = enc_r(5'd0, 5'd6, 5'd11, 5'd4, 6'h00);// sll   $11,$6,4
        mem[7] = enc_r(5'd8, 5'd8, 5'd12, 5'd0, 6'h21);// addu  $12,$8,$8
        do_reset();
        run(32);
        check("alu_n_ret", ret_q.size(), 32'd8);
        dbg_sel = {5'd8, 5'd7, 5'd5, 5'd6};
        #1;
        check("alu_addiu", dbg_data[31:0],  32'd3);
        check("alu_lui",   dbg_data[63:32], 32'h8000_0000);
        check("alu_slt",   dbg_data[95:64], 32'd1);
        check("alu_subu",  dbg_data[127:96], 32'h8000_0003);
        dbg_sel = {5'd12, 5'd11, 5'd10, 5'd9};
        #1;
        check("alu_and",  dbg_data[31:0],  32'd3);
        check("alu_or",   dbg_data[63:32], 32'h8000_0003);
        check("alu_sll",  dbg_data[95:64], 32'h30);
        check("alu_addu", dbg_data[127:96], 32'h6);

        // sw with 3 write wait states, then zero-wait lw of the same word
        clear_mem();
        mem[0] = enc_i(6'h09, 5'd0, 5'd4, 16'h00A5);   // addiu $4,$0,0xA5
        mem[1] = enc_i(6'h2B, 5'd0, 5'd4, 16'd16);     // sw    $4,16($0)
        mem[2] = enc_i(6'h23, 5'd0, 5'd2, 16'd16);     // lw    $2,16($0)
        we_wait = 3;
        exp_st_addr = 32'd16;
        exp_st_data = 32'hA5;
        do_reset();
        run(16);
        exp_q.push_back(4); exp_q.push_back(11); exp_q.push_back(16);
        check_retires("mem_ret");
        check("sw_we_cycles", we_cycles, 32'd4);
        check("sw_stable", we_bad, 32'd0);
        check("re_we_excl", both, 32'd0);
        get_reg(5'd2, rv); check("lw_r2", rv, 32'hA5);
        we_wait = 0;

        // beq taken with offset -1 at 0x20
        clear_mem();
        mem[0] = enc_j(6'h02, 26'h8);                  // j 0x20
        mem[8] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);   // beq $0,$0,-1
        do_reset();
        run(6);
        exp_q.push_back(2); exp_q.push_back(5);
        check_retires("beq_t_ret");
        check("beq_t_pc4", pc_hist[3], 32'h24);
        check("beq_t_pc6", pc_hist[5], 32'h20);

        // beq not taken
        clear_mem();
        mem[0] = enc_i(6'h09, 5'd0, 5'd1, 16'd1);      // addiu $1,$0,1
        mem[1] = enc_j(6'h02, 26'h8);                  // j 0x20
        mem[8] = enc_i(6'h04, 5'd1, 5'd0, 16'hFFFF);   // beq $1,$0,-1
        do_reset();
        run(9);
        exp_q.push_back(4); exp_q.push_back(6); exp_q.push_back(9);
        check_retires("beq_n_ret");
        check("beq_n_pc", pc_o, 32'h24);

        // jal 0x40 -> 0x100, then jr $31
        clear_mem();
        mem[0]  = enc_j(6'h02, 26'h10);                // j   0x40
        mem[16] = enc_j(6'h03, 26'h40);                // jal 0x100
        mem[64] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08); // jr $31
        do_reset();
        run(6);
        exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(6);
        check_retires("jump_ret");
        check("jal_pc", pc_hist[4], 32'h100);
        check("jr_pc", pc_o, 32'h44);
        get_reg(5'd31, rv); check("jal_r31", rv, 32'h44);

        // $0 write discarded, then illegal opcode halts
        clear_mem();
        mem[0] = enc_i(6'h09, 5'd0, 5'd0, 16'd9);      // addiu $0,$0,9
        mem[1] = 32'hFC00_0000;                        // opcode 6'h3F
        do_reset();
        run(20);
        exp_q.push_back(4);
        check_retires("halt_ret");
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_state", {29'd0, core_state}, 32'd5);
        check("halt_re_cycles", re_cycles, 32'd2);
        check("halt_pc", pc_o, 32'h8);
        get_reg(5'd0, rv); check("zero_reg", rv, 32'd0);
`ifdef MC_CPU_PERF_CNT_EN
        check("halt_cycle_cnt", cycle_cnt, 32'd6);
        check("halt_instr_cnt", instr_cnt, 32'd1);
`endif
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("halt_rst_flag", {31'd0, halted}, 32'd0);
        check("halt_rst_pc", pc_o, 32'h0);

        // Reset while a fetch is waiting on memory
        clear_mem();
        re_wait = 5;
        do_reset();
        run(2);
        check("wait_re", {31'd0, mem_re}, 32'd1);
        reset = 1'b1;
        #1;
        check("wait_rst_re", {31'd0, mem_re}, 32'd0);
        re_wait = 0;

`ifdef MC_CPU_PERF_CNT_EN
        // Three zero-wait R-type NOPs (sll $0,$0,0)
        clear_mem();
        do_reset();
        check("perf_rst_cyc", cycle_cnt, 32'd0);
        run(12);
        check("perf_instr", instr_cnt, 32'd3);
        check("perf_cycle", cycle_cnt, 32'd12);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
